// File: rtl/hdr_tonemap.sv
// HDR tonemapper: per-channel min/max normalisation of log radiance to RGB565, 4-entry output FIFO.
// Optional `HDR_TM_BYPASS_EN adds tm_bypass, which passes the top lE bits straight through.
module hdr_tonemap #(
    parameter int unsigned N       = 8,
    parameter int unsigned FP      = 4,
    parameter int unsigned FIFO_AW = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         frame_start,
    input  logic         hdr_done,
    input  logic [N-1:0] lE_red,
    input  logic [N-1:0] lE_green,
    input  logic [N-1:0] lE_blue,
`ifdef HDR_TM_BYPASS_EN
    input  logic         tm_bypass,
`endif
    input  logic         out_ready,
    output logic         tm_valid,
    output logic [4:0]   out_red,
    output logic [5:0]   out_green,
    output logic [4:0]   out_blue,
    output logic         tm_ovf
);

    localparam int unsigned PW    = $clog2(N);
    localparam int unsigned TW    = N + 6;
    localparam int unsigned Depth = 1 << FIFO_AW;

    if (FP > N) begin : g_fp_range
        $error("hdr_tonemap: FP must not exceed N");
    end

    function automatic logic [PW-1:0] msb_idx(input logic [N-1:0] v);
        logic [PW-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) idx = PW'(i);
        end
        return idx;
    endfunction

    // (d << w) >> (p + 1), saturated to w bits
    function automatic logic [5:0] scale(input logic [N-1:0] d, input logic [PW-1:0] p,
                                         input int unsigned w);
        logic [TW-1:0] t;
        logic [TW-1:0] lim;
        t   = (TW'(d) << w) >> ({1'b0, p} + 1'b1);
        lim = TW'((1 << w) - 1);
        return (t > lim) ? 6'(lim) : 6'(t);
    endfunction

    logic [N-1:0] le [3];

    assign le[0] = lE_red;
    assign le[1] = lE_green;
    assign le[2] = lE_blue;

    // ---------------- Range statistics ----------------
    logic [N-1:0] tmin_q [3];
    logic [N-1:0] tmax_q [3];
    logic [N-1:0] amin_q [3];
    logic [N-1:0] amax_q [3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < 3; c++) begin
                tmin_q[c] <= '1;
                tmax_q[c] <= '0;
                amin_q[c] <= '0;
                amax_q[c] <= '1;
            end
        end else begin
            for (int c = 0; c < 3; c++) begin
                if (frame_start) begin
                    // An empty frame leaves the trackers inverted; keep the old mapping then.
                    if (tmax_q[c] >= tmin_q[c]) begin
                        amin_q[c] <= tmin_q[c];
                        amax_q[c] <= tmax_q[c];
                    end
                    tmin_q[c] <= hdr_done ? le[c] : '1;
                    tmax_q[c] <= hdr_done ? le[c] : '0;
                end else if (hdr_done) begin
                    if (le[c] < tmin_q[c]) tmin_q[c] <= le[c];
                    if (le[c] > tmax_q[c]) tmax_q[c] <= le[c];
                end
            end
        end
    end

    // ---------------- Stage 1: offset and range exponent ----------------
    logic [N-1:0]  d1_d [3];
    logic [PW-1:0] p1_d [3];
    logic [N-1:0]  rng;

    always_comb begin
        rng = '0;
        for (int c = 0; c < 3; c++) begin
            rng     = amax_q[c] - amin_q[c];
            d1_d[c] = (le[c] < amin_q[c]) ? '0 : le[c] - amin_q[c];
            p1_d[c] = msb_idx(rng);
        end
    end

    logic          s1_valid_q;
    logic [N-1:0]  d1_q [3];
    logic [PW-1:0] p1_q [3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            for (int c = 0; c < 3; c++) begin
                d1_q[c] <= '0;
                p1_q[c] <= '0;
            end
        end else begin
            s1_valid_q <= hdr_done;
            for (int c = 0; c < 3; c++) begin
                d1_q[c] <= d1_d[c];
                p1_q[c] <= p1_d[c];
            end
        end
    end

`ifdef HDR_TM_BYPASS_EN
    logic       byp1_q;
    logic [4:0] top_r_q;
    logic [5:0] top_g_q;
    logic [4:0] top_b_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byp1_q  <= 1'b0;
            top_r_q <= '0;
            top_g_q <= '0;
            top_b_q <= '0;
        end else begin
            byp1_q  <= tm_bypass;
            top_r_q <= lE_red[N-1 -: 5];
            top_g_q <= lE_green[N-1 -: 6];
            top_b_q <= lE_blue[N-1 -: 5];
        end
    end
`endif

    // ---------------- Stage 2: power-of-two scaling ----------------
    logic [4:0] o_r;
    logic [5:0] o_g;
    logic [4:0] o_b;

    always_comb begin
        o_r = 5'(scale(d1_q[0], p1_q[0], 5));
        o_g = scale(d1_q[1], p1_q[1], 6);
        o_b = 5'(scale(d1_q[2], p1_q[2], 5));
`ifdef HDR_TM_BYPASS_EN
        if (byp1_q) begin
            o_r = top_r_q;
            o_g = top_g_q;
            o_b = top_b_q;
        end
`endif
    end

    logic        s2_valid_q;
    logic [15:0] pix2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            pix2_q     <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            pix2_q     <= {o_r, o_g, o_b};
        end
    end

    // ---------------- Output FIFO ----------------
    logic [15:0]      mem_q [Depth];
    logic [FIFO_AW:0] wr_ptr_q;
    logic [FIFO_AW:0] rd_ptr_q;
    logic [15:0]      last_q;
    logic             ovf_q;
    logic             empty;
    logic             full;
    logic             rd_en;
    logic             wr_en;
    logic             drop;
    logic [15:0]      head;

    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]) &&
                (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]);
        rd_en = !empty && out_ready;
        // A simultaneous pop frees the slot, so a full FIFO still accepts the write.
        wr_en = s2_valid_q && (!full || rd_en);
        drop  = s2_valid_q && full && !rd_en;
        head  = mem_q[rd_ptr_q[FIFO_AW-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            last_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q[FIFO_AW-1:0]] <= pix2_q;
                wr_ptr_q                     <= wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                last_q   <= head;
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (frame_start) begin
                ovf_q <= 1'b0;
            end
        end
    end

    always_comb begin
        tm_valid                      = !empty;
        tm_ovf                        = ovf_q;
        {out_red, out_green, out_blue} = empty ? last_q : head;
    end

endmodule
